// File: rtl/soc_mem_pkg.sv
// Shared definitions for the RISCVSoC data-memory arbiter.
//   - arb_state_e : arbitration FSM states (IDLE / CPU / ACC_BURST)
//   - owner_e     : tag recording which requester owns the pending read return
//   - ADDR_W_DEF / DATA_W_DEF : default address and data widths
package soc_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CPU       = 2'd1,
    ST_ACC_BURST = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_ACC  = 2'd2
  } owner_e;

endpackage

// File: rtl/soc_mem_rdmux.sv
// Read-return steering for the shared data memory.
// Registers which requester issued the read granted this cycle and, one cycle
// later, routes mem_rdata to that requester with its rvalid. The requester
// that does not own the return sees rdata = 0.
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_gnt, acc_gnt    : grants issued this cycle (at most one high)
//   mem_we              : write enable of the access presented this cycle
//   mem_rdata           : memory read data (valid one cycle after a read)
//   cpu_rvalid/cpu_rdata: CPU read return
//   acc_rvalid/acc_rdata: accelerator read return
module soc_mem_rdmux
  import soc_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_gnt,
  input  logic              acc_gnt,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata
);

  owner_e owner_p0;
  owner_e owner_p1;

  // Stage p0: tag the read accepted this cycle; writes leave no tag.
  always_comb begin
    owner_p0 = OWN_NONE;
    if (!mem_we) begin
      if (cpu_gnt) begin
        owner_p0 = OWN_CPU;
      end else if (acc_gnt) begin
        owner_p0 = OWN_ACC;
      end
    end
  end

  // Stage p1: tag lines up with the memory's registered read data.
  // Reset drops any pending return so no rvalid appears after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_p1 <= OWN_NONE;
    end else begin
      owner_p1 <= owner_p0;
    end
  end

  assign cpu_rvalid = (owner_p1 == OWN_CPU);
  assign acc_rvalid = (owner_p1 == OWN_ACC);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign acc_rdata  = acc_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/soc_mem_arbiter.sv
// Per-cycle arbiter sharing the single-port data memory between the CPU
// load/store port and the accelerator DMA port.
//   - CPU has priority; the accelerator wins when the CPU is idle or after
//     STARVE_LIM consecutive CPU grants while it was waiting.
//   - The accelerator may lock the port for a burst of up to MAX_BURST beats.
//   - debug blocks new accelerator grants (an in-flight burst beat completes
//     and the burst is then released); the CPU is still served.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   debug                            : freeze accelerator traffic
//   cpu_req/we/addr/wdata, cpu_gnt   : CPU request channel and grant
//   cpu_rvalid/cpu_rdata             : CPU read return (one cycle after grant)
//   acc_req/lock/we/addr/wdata, acc_gnt : accelerator request channel, grant
//   acc_rvalid/acc_rdata             : accelerator read return
//   mem_en/we/addr/wdata, mem_rdata  : single-port memory interface
module soc_mem_arbiter
  import soc_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_BURST  = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              acc_req,
  input  logic              acc_lock,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  // A lock is only worth entering when the burst can hold more than one beat.
  localparam bit LOCK_OK = (MAX_BURST > 1);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            acc_win;

  // Accelerator beats the CPU only when the CPU is idle or it has waited
  // STARVE_LIM CPU grants in a row.
  assign acc_win = acc_req && !debug && (!cpu_req || (starve_q == STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    cpu_gnt  = 1'b0;
    acc_gnt  = 1'b0;
    // Grants are combinational; holding them low during reset keeps the
    // memory strobe quiet while rst is asserted.
    if (!rst) begin
      case (state_q)
        ST_ACC_BURST: begin
          starve_d = '0;
          acc_gnt  = acc_req;
          if (acc_req) begin
            burst_d = burst_q + 1'b1;
          end
          // Release on idle, lock drop, debug, or the final permitted beat.
          if (!acc_req || !acc_lock || debug || (burst_q == BURST_LAST)) begin
            state_d = ST_IDLE;
            burst_d = '0;
          end
        end
        default: begin
          if (acc_win) begin
            acc_gnt  = 1'b1;
            starve_d = '0;
            if (acc_lock && LOCK_OK) begin
              state_d = ST_ACC_BURST;
              burst_d = BW'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
            state_d = ST_CPU;
            if (acc_req) begin
              starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
          end else begin
            state_d  = ST_IDLE;
            starve_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  assign mem_en    = cpu_gnt | acc_gnt;
  assign mem_we    = acc_gnt ? acc_we    : (cpu_gnt ? cpu_we    : 1'b0);
  assign mem_addr  = acc_gnt ? acc_addr  : (cpu_gnt ? cpu_addr  : '0);
  assign mem_wdata = acc_gnt ? acc_wdata : (cpu_gnt ? cpu_wdata : '0);

  soc_mem_rdmux #(
    .DATA_W(DATA_W)
  ) u_rdmux (
    .clk       (clk),
    .rst       (rst),
    .cpu_gnt   (cpu_gnt),
    .acc_gnt   (acc_gnt),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .acc_rvalid(acc_rvalid),
    .acc_rdata (acc_rdata)
  );

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter with an in-bench behavioural model
// (ownership flag, beat/wait counts, memory image, pending-read queue).
module tb_soc_mem_arbiter;

  localparam int MAX_BURST  = 8;
  localparam int STARVE_LIM = 4;

  logic        clk;
  logic        rst;
  logic        debug;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        acc_req, acc_lock, acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_gnt, acc_rvalid;
  logic [31:0] acc_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  soc_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst), .debug(debug),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .acc_req(acc_req), .acc_lock(acc_lock), .acc_we(acc_we), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: registered read data, cleared on reset.
  logic [31:0] smem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) smem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_en && !mem_we) mem_rdata <= smem[mem_addr[9:2]];
      else                   mem_rdata <= 32'h0;
      if (mem_en && mem_we)  smem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int checks;
  int errors;

  // Behavioural model state.
  bit          m_own;      // accelerator currently owns the port
  int          m_beats;    // beats taken in the current ownership
  int          m_waits;    // consecutive CPU wins while accelerator waited
  int          m_pend;     // 0 none, 1 CPU, 2 ACC read return due next cycle
  logic [31:0] m_pdata;
  logic [31:0] mm [256];

  // Snapshot of DUT outputs at the last sample point plus a grant log.
  logic        s_cpu_gnt, s_acc_gnt, s_cpu_rvalid, s_acc_rvalid, s_mem_en, s_mem_we;
  logic [31:0] s_cpu_rdata, s_acc_rdata, s_mem_addr, s_mem_wdata;
  string       glog;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  // One clock cycle: sample and compare against the model at the negedge,
  // advance the model, then return just after the next rising edge.
  task automatic step();
    logic        e_c, e_a, e_we, e_crv, e_arv;
    logic [31:0] e_addr, e_wd, e_crd, e_ard;
    @(negedge clk);
    e_c = 1'b0; e_a = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
    e_crv = !rst && (m_pend == 1);
    e_arv = !rst && (m_pend == 2);
    e_crd = e_crv ? m_pdata : 32'h0;
    e_ard = e_arv ? m_pdata : 32'h0;
    if (!rst) begin
      if (m_own) e_a = acc_req;
      else if (acc_req && !debug && (!cpu_req || m_waits == STARVE_LIM)) e_a = 1'b1;
      else e_c = cpu_req;
      if (e_a) begin e_we = acc_we; e_addr = acc_addr; e_wd = acc_wdata; end
      if (e_c) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
    end
    chk("cpu_gnt",    {31'h0, cpu_gnt},    {31'h0, e_c});
    chk("acc_gnt",    {31'h0, acc_gnt},    {31'h0, e_a});
    chk("mem_en",     {31'h0, mem_en},     {31'h0, e_c | e_a});
    chk("mem_we",     {31'h0, mem_we},     {31'h0, e_we});
    chk("mem_addr",   mem_addr,            e_addr);
    chk("mem_wdata",  mem_wdata,           e_wd);
    chk("cpu_rvalid", {31'h0, cpu_rvalid}, {31'h0, e_crv});
    chk("cpu_rdata",  cpu_rdata,           e_crd);
    chk("acc_rvalid", {31'h0, acc_rvalid}, {31'h0, e_arv});
    chk("acc_rdata",  acc_rdata,           e_ard);

    if (rst) begin
      m_own = 1'b0; m_beats = 0; m_waits = 0; m_pend = 0;
      for (int i = 0; i < 256; i++) mm[i] = 32'h0;
    end else begin
      if (e_c || e_a) begin
        if (e_we) begin
          mm[e_addr[9:2]] = e_wd;
          m_pend = 0;
        end else begin
          m_pend  = e_a ? 2 : 1;
          m_pdata = mm[e_addr[9:2]];
        end
      end else begin
        m_pend = 0;
      end
      if (m_own) begin
        if (e_a) m_beats++;
        if (!acc_req || !acc_lock || debug || m_beats >= MAX_BURST) m_own = 1'b0;
        m_waits = 0;
      end else if (e_a) begin
        m_waits = 0;
        if (acc_lock && MAX_BURST > 1) begin m_own = 1'b1; m_beats = 1; end
      end else if (e_c) begin
        m_waits = acc_req ? ((m_waits < STARVE_LIM) ? m_waits + 1 : STARVE_LIM) : 0;
      end else begin
        m_waits = 0;
      end
    end

    s_cpu_gnt = cpu_gnt; s_acc_gnt = acc_gnt; s_cpu_rvalid = cpu_rvalid;
    s_acc_rvalid = acc_rvalid; s_mem_en = mem_en; s_mem_we = mem_we;
    s_cpu_rdata = cpu_rdata; s_acc_rdata = acc_rdata;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    if (cpu_gnt && acc_gnt) glog = {glog, "X"};
    else if (cpu_gnt)       glog = {glog, "C"};
    else if (acc_gnt)       glog = {glog, "A"};
    else                    glog = {glog, "-"};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    debug = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    acc_req = 1'b0; acc_lock = 1'b0; acc_we = 1'b0; acc_addr = 32'h0; acc_wdata = 32'h0;
  endtask

  int          beats;
  int          n;
  bit          cpu_done;
  logic [31:0] rv_data;

  initial begin
    checks = 0; errors = 0;
    m_own = 1'b0; m_beats = 0; m_waits = 0; m_pend = 0; m_pdata = 32'h0;
    for (int i = 0; i < 256; i++) mm[i] = 32'h0;
    glog = "";
    rst = 1'b1;
    idle_inputs();

    // Reset state
    step(); step();
    chk("rst_cpu_gnt", {31'h0, s_cpu_gnt}, 32'h0);
    chk("rst_mem_en", {31'h0, s_mem_en}, 32'h0);
    chk("rst_rvalid", {30'h0, s_cpu_rvalid, s_acc_rvalid}, 32'h0);
    chk("rst_mem_addr", s_mem_addr, 32'h0);
    rst = 1'b0;
    step();

    // CPU write then read of 0x100
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    step();
    chk("t1_wr_gnt", {31'h0, s_cpu_gnt}, 32'h1);
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    step();
    chk("t1_rd_gnt", {31'h0, s_cpu_gnt}, 32'h1);
    chk("t1_rd_addr", s_mem_addr, 32'h100);
    cpu_req = 1'b0;
    step();
    chk("t1_rvalid", {31'h0, s_cpu_rvalid}, 32'h1);
    chk("t1_rdata", s_cpu_rdata, 32'hDEADBEEF);
    chk("t1_acc_rvalid", {31'h0, s_acc_rvalid}, 32'h0);

    // Both requesting continuously: starvation pattern
    glog = "";
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    acc_req = 1'b1; acc_lock = 1'b0; acc_we = 1'b0; acc_addr = 32'h100;
    for (int i = 0; i < 10; i++) step();
    chk_str("t2_pattern", glog, "CCCCACCCCA");
    idle_inputs();
    step(); step();

    // Locked burst of 12 writes, CPU requesting once mid-burst
    glog = ""; beats = 0; cpu_done = 1'b0; n = 0; rv_data = 32'h0;
    acc_req = 1'b1; acc_lock = 1'b1; acc_we = 1'b1;
    acc_addr = 32'h200; acc_wdata = 32'hA0000000;
    cpu_we = 1'b0; cpu_addr = 32'h204;
    while (beats < 12 && n < 40) begin
      step();
      n++;
      if (s_acc_gnt) beats++;
      if (s_cpu_gnt) cpu_done = 1'b1;
      if (s_cpu_rvalid) rv_data = s_cpu_rdata;
      acc_addr  = 32'h200 + 32'(4 * beats);
      acc_wdata = 32'hA0000000 + 32'(beats);
      if (beats >= 12) begin acc_req = 1'b0; acc_lock = 1'b0; end
      cpu_req = !cpu_done && (beats >= 1);
    end
    chk("t3_beats", 32'(beats), 32'd12);
    chk_str("t3_pattern", glog, "AAAAAAAACAAAA");
    chk("t3_cpu_raw", rv_data, 32'hA0000001);
    idle_inputs();
    step();

    // debug raised on the 3rd burst beat
    glog = "";
    acc_req = 1'b1; acc_lock = 1'b1; acc_we = 1'b0; acc_addr = 32'h200;
    step(); step();
    debug = 1'b1;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    step(); step();
    chk("t4_cpu_rvalid", {31'h0, s_cpu_rvalid}, 32'h1);
    chk("t4_cpu_rdata", s_cpu_rdata, 32'hDEADBEEF);
    step(); step();
    debug = 1'b0; cpu_req = 1'b0;
    step();
    acc_req = 1'b0; acc_lock = 1'b0;
    step();
    chk_str("t4_pattern", glog, "AAACCCCA-");
    idle_inputs();
    step();

    // Accelerator write then CPU read of the same address
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = 32'h40; acc_wdata = 32'h55;
    step();
    chk("t6_acc_gnt", {31'h0, s_acc_gnt}, 32'h1);
    chk("t6_wr_we", {31'h0, s_mem_we}, 32'h1);
    chk("t6_wr_data", s_mem_wdata, 32'h55);
    acc_req = 1'b0; acc_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    step();
    chk("t6_rd_we", {31'h0, s_mem_we}, 32'h0);
    chk("t6_rd_addr", s_mem_addr, 32'h40);
    cpu_req = 1'b0;
    step();
    chk("t6_rdata", s_cpu_rdata, 32'h55);

    // Reset one cycle after an accelerator read grant
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 32'h40;
    step();
    chk("t5_acc_gnt", {31'h0, s_acc_gnt}, 32'h1);
    rst = 1'b1;
    idle_inputs();
    step();
    chk("t5_acc_rvalid", {31'h0, s_acc_rvalid}, 32'h0);
    chk("t5_acc_rdata", s_acc_rdata, 32'h0);
    rst = 1'b0;
    step(); step();
    chk("t5_post_rvalid", {30'h0, s_cpu_rvalid, s_acc_rvalid}, 32'h0);
    chk("t5_post_en", {31'h0, s_mem_en}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
